// File: rtl/fp_alu_pkg.sv
// ---------------------------------------------------------------------------
// fp_alu_pkg
//   Shared constants, FSM state type and fp32 field helpers for the
//   floating-point ALU units.
//   Contents:
//     EXP_W, MAN_W, BIAS, EXP_MAX  - IEEE-754 single-precision format
//     ESUM_W, BIAS_S               - signed exponent arithmetic width/bias
//     PROD_W                       - full mantissa product width
//     fpmul_state_e                - IDLE, UNPACK, MULT, NORM, DONE
//     fp_sign / fp_exp / fp_man    - fp32 field slices
// ---------------------------------------------------------------------------
package fp_alu_pkg;

   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int BIAS   = 127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   // Exponent sum of two biased exponents, kept signed so that values below
   // zero (deep underflow) stay representable through normalisation.
   localparam int ESUM_W = 10;
   localparam logic signed [ESUM_W-1:0] BIAS_S = 10'sd127;

   localparam int PROD_W = 2 * (MAN_W + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      MULT   = 3'd2,
      NORM   = 3'd3,
      DONE   = 3'd4
   } fpmul_state_e;

   function automatic logic fp_sign(input logic [31:0] f);
      return f[31];
   endfunction

   function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] f);
      return f[30:23];
   endfunction

   function automatic logic [MAN_W-1:0] fp_man(input logic [31:0] f);
      return f[22:0];
   endfunction

endpackage

// File: rtl/fp_mult_norm_round.sv
// ---------------------------------------------------------------------------
// fp_mult_norm_round
//   Combinational normalise + round-to-nearest-even + special-case packing
//   for the sequential fp32 multiplier. The caller registers the outputs.
//   Ports:
//     sign_i       in   result sign
//     esum_i       in   signed sum of the two biased exponents
//     prod_i       in   48-bit product of the two 24-bit mantissas
//     exc_i        in   an operand had exponent all-0s or all-1s
//     result_o     out  packed fp32 result
//     exception_o  out  exception flag
//     overflow_o   out  biased exponent > 254 after rounding
//     underflow_o  out  biased exponent < 1 after rounding
// ---------------------------------------------------------------------------
module fp_mult_norm_round
   import fp_alu_pkg::*;
(
   input  logic                     sign_i,
   input  logic signed [ESUM_W-1:0] esum_i,
   input  logic [PROD_W-1:0]        prod_i,
   input  logic                     exc_i,
   output logic [31:0]              result_o,
   output logic                     exception_o,
   output logic                     overflow_o,
   output logic                     underflow_o
);

   logic [MAN_W-1:0]        man_raw;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;
   logic [MAN_W:0]          man_rnd;
   logic signed [ESUM_W-1:0] exp_n;
   logic signed [ESUM_W-1:0] exp_r;

   always_comb begin
      // Product of two 1.x mantissas lies in [1,4): bit 47 set means the
      // leading one sits one place higher and the exponent gains one.
      if (prod_i[PROD_W-1]) begin
         man_raw = prod_i[46:24];
         guard   = prod_i[23];
         sticky  = |prod_i[22:0];
         exp_n   = esum_i - BIAS_S + 10'sd1;
      end else begin
         man_raw = prod_i[45:23];
         guard   = prod_i[22];
         sticky  = |prod_i[21:0];
         exp_n   = esum_i - BIAS_S;
      end

      round_up = guard & (sticky | man_raw[0]);
      man_rnd  = {1'b0, man_raw} + {{MAN_W{1'b0}}, round_up};
      // A carry out of the mantissa leaves its low bits all zero, so only the
      // exponent needs adjusting.
      exp_r    = exp_n + $signed({{(ESUM_W-1){1'b0}}, man_rnd[MAN_W]});

      result_o    = 32'h0000_0000;
      exception_o = 1'b0;
      overflow_o  = 1'b0;
      underflow_o = 1'b0;
      if (exc_i) begin
         exception_o = 1'b1;
      end else if (exp_r > 10'sd254) begin
         overflow_o = 1'b1;
         result_o   = {sign_i, EXP_MAX, {MAN_W{1'b0}}};
      end else if (exp_r < 10'sd1) begin
         underflow_o = 1'b1;
         result_o    = {sign_i, 31'd0};
      end else begin
         result_o = {sign_i, exp_r[EXP_W-1:0], man_rnd[MAN_W-1:0]};
      end
   end

endmodule

// File: rtl/alu_fp_multiply_seq.sv
// ---------------------------------------------------------------------------
// alu_fp_multiply_seq
//   Sequential IEEE-754 single-precision multiplier, shift-add mantissa core.
//   Build option: define FPMUL_RADIX4_EN to retire two multiplier bits per
//   MULT cycle (12 cycles, out_valid after E0+14); otherwise one bit per
//   cycle (24 cycles, out_valid after E0+26). Results are identical.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     in_valid      operands valid
//     in_ready      operands accepted (high only in IDLE)
//     a_operand     multiplicand fp32
//     b_operand     multiplier fp32
//     out_valid     result valid, held until out_ready
//     out_ready     consumer takes result
//     result        fp32 product
//     exception     an operand exponent was all-0s or all-1s
//     overflow      result exponent above 254
//     underflow     result exponent below 1
//     dbg_state     current FSM state
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid, once raised, holds with stable data until that edge.
// ---------------------------------------------------------------------------
module alu_fp_multiply_seq
   import fp_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        exception,
   output logic        overflow,
   output logic        underflow,
   output logic [2:0]  dbg_state
);

`ifdef FPMUL_RADIX4_EN
   localparam int MULT_ITERS = 12;
`else
   localparam int MULT_ITERS = 24;
`endif

   fpmul_state_e state_q, state_d;

   logic [31:0]              a_q, b_q;
   logic                     sign_q;
   logic signed [ESUM_W-1:0] esum_q;
   logic                     exc_q;
   logic [MAN_W:0]           ma_q;
   logic [MAN_W:0]           mb_q;
   logic [PROD_W-1:0]        acc_q, acc_d;
   logic [4:0]               cnt_q;
   logic [31:0]              result_q;
   logic                     exc_flag_q, ovf_q, unf_q;

   logic [31:0]              nr_result;
   logic                     nr_exc, nr_ovf, nr_unf;

`ifdef FPMUL_RADIX4_EN
   logic [MAN_W+2:0]         ma3_q;
   logic [MAN_W+2:0]         addend;
   logic [MAN_W+2:0]         upper;
`else
   logic [MAN_W:0]           addend;
   logic [MAN_W+1:0]         upper;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)      state_d = UNPACK;
         UNPACK:                     state_d = MULT;
         MULT:    if (cnt_q == 5'd0) state_d = NORM;
         NORM:                       state_d = DONE;
         DONE:    if (out_ready)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      dbg_state = state_q;
   end

   // ---------------- Shift-add step ----------------
   // The partial product is added into the top half of the accumulator and
   // the whole accumulator shifts right, so no product bits are ever lost.
   always_comb begin
`ifdef FPMUL_RADIX4_EN
      case (mb_q[1:0])
         2'd0:    addend = '0;
         2'd1:    addend = {2'b00, ma_q};
         2'd2:    addend = {1'b0, ma_q, 1'b0};
         default: addend = ma3_q;
      endcase
      upper = {2'b00, acc_q[PROD_W-1:24]} + addend;
      acc_d = {upper, acc_q[23:2]};
`else
      addend = mb_q[0] ? ma_q : '0;
      upper  = {1'b0, acc_q[PROD_W-1:24]} + {1'b0, addend};
      acc_d  = {upper, acc_q[23:1]};
`endif
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         sign_q     <= 1'b0;
         esum_q     <= '0;
         exc_q      <= 1'b0;
         ma_q       <= '0;
         mb_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         exc_flag_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
`ifdef FPMUL_RADIX4_EN
         ma3_q      <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q <= a_operand;
                  b_q <= b_operand;
               end
            end
            UNPACK: begin
               sign_q <= fp_sign(a_q) ^ fp_sign(b_q);
               esum_q <= $signed({2'b00, fp_exp(a_q)} + {2'b00, fp_exp(b_q)});
               exc_q  <= (fp_exp(a_q) == '0) || (fp_exp(a_q) == EXP_MAX) ||
                         (fp_exp(b_q) == '0) || (fp_exp(b_q) == EXP_MAX);
               ma_q   <= {1'b1, fp_man(a_q)};
               mb_q   <= {1'b1, fp_man(b_q)};
               acc_q  <= '0;
               cnt_q  <= 5'(MULT_ITERS - 1);
`ifdef FPMUL_RADIX4_EN
               ma3_q  <= {2'b00, 1'b1, fp_man(a_q)} + {1'b0, 1'b1, fp_man(a_q), 1'b0};
`endif
            end
            MULT: begin
               acc_q <= acc_d;
`ifdef FPMUL_RADIX4_EN
               mb_q  <= mb_q >> 2;
`else
               mb_q  <= mb_q >> 1;
`endif
               cnt_q <= cnt_q - 5'd1;
            end
            NORM: begin
               result_q   <= nr_result;
               exc_flag_q <= nr_exc;
               ovf_q      <= nr_ovf;
               unf_q      <= nr_unf;
            end
            default: ;
         endcase
      end
   end

   fp_mult_norm_round u_norm (
      .sign_i      (sign_q),
      .esum_i      (esum_q),
      .prod_i      (acc_q),
      .exc_i       (exc_q),
      .result_o    (nr_result),
      .exception_o (nr_exc),
      .overflow_o  (nr_ovf),
      .underflow_o (nr_unf)
   );

   assign result    = result_q;
   assign exception = exc_flag_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_alu_fp_multiply_seq.sv
module tb_alu_fp_multiply_seq;
   import fp_alu_pkg::*;

`ifdef FPMUL_RADIX4_EN
   localparam int LAT = 14;
`else
   localparam int LAT = 26;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a_operand, b_operand, result;
   logic        exception, overflow, underflow;
   logic [2:0]  dbg_state;

   alu_fp_multiply_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_operand (a_operand),
      .b_operand (b_operand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .exception (exception),
      .overflow  (overflow),
      .underflow (underflow),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [34:0] exp_q[$];

   task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference: exact integer product, then round-to-nearest-even by
   // comparing the discarded remainder against one half.
   // Returns {exception, overflow, underflow, result}.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
      int ea, eb, e, sh;
      longint unsigned ma, mb, prod, q, rem, half;
      logic s;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 0 || ea == 255 || eb == 0 || eb == 255) return {3'b100, 32'd0};
      s    = a[31] ^ b[31];
      ma   = 64'(a[22:0]) + 64'd8388608;
      mb   = 64'(b[22:0]) + 64'd8388608;
      prod = ma * mb;
      e    = ea + eb - 127;
      if (prod >= (64'd1 << 47)) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e > 254)    return {3'b010, s, 8'hFF, 23'd0};
      else if (e < 1) return {3'b001, s, 31'd0};
      else            return {3'b000, s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [34:0] observed();
      return {exception, overflow, underflow, result};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
      int lat;
      logic [34:0] exp_v;
      exp_q.push_back(model(a, b));
      lat = 0;
      while (!in_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("in_ready_idle", 35'(in_ready), 35'd1);
      in_valid  = 1'b1;
      a_operand = a;
      b_operand = b;
      @(negedge clk);
      in_valid  = 1'b0;
      a_operand = $urandom;
      b_operand = $urandom;
      check("in_ready_busy", 35'(in_ready), 35'd0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 35'(lat), 35'(LAT));
      exp_v = exp_q.pop_front();
      check("result", observed(), exp_v);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_result", observed(), exp_v);
         check("hold_valid_ready", 35'({out_valid, in_ready}), 35'b10);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid_ready", 35'({out_valid, in_ready}), 35'b01);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      logic [7:0]  e;
      v = $urandom;
      case ($urandom_range(0, 9))
         0:       e = 8'd0;
         1:       e = 8'hFF;
         2:       e = 8'($urandom_range(1, 20));
         3:       e = 8'($urandom_range(235, 254));
         default: e = 8'($urandom_range(64, 190));
      endcase
      v[30:23] = e;
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_operand = '0;
      b_operand = '0;

      do_reset();
      check("reset_result_flags", observed(), 35'd0);
      check("reset_valid_ready", 35'({out_valid, in_ready}), 35'b01);
      check("reset_state", 35'(dbg_state), 35'(IDLE));

      // Directed cases
      run_op(32'h4040_0000, 32'h4000_0000, 10);
      check("dir_3x2", 35'({exception, overflow, underflow, result}), {3'b000, 32'h40C0_0000});
      run_op(32'hC020_0000, 32'h4080_0000, 0);
      check("dir_neg", observed(), {3'b000, 32'hC120_0000});
      run_op(32'h3FC0_0000, 32'h3FC0_0000, 1);
      check("dir_1p5sq", observed(), {3'b000, 32'h4010_0000});
      run_op(32'h3F80_0001, 32'h3F80_0001, 0);
      check("dir_round", observed(), {3'b000, 32'h3F80_0002});
      run_op(32'h7F00_0000, 32'h7F00_0000, 0);
      check("dir_overflow", observed(), {3'b010, 32'h7F80_0000});
      run_op(32'h0080_0000, 32'h0080_0000, 0);
      check("dir_underflow", observed(), {3'b001, 32'h0000_0000});
      run_op(32'h7F80_0000, 32'h4000_0000, 0);
      check("dir_exception", observed(), {3'b100, 32'h0000_0000});

      // Reset in the middle of MULT: the job is lost
      @(negedge clk);
      in_valid  = 1'b1;
      a_operand = 32'h4040_0000;
      b_operand = 32'h4040_0000;
      @(negedge clk);
      in_valid  = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_valid_ready", 35'({out_valid, in_ready}), 35'b01);
      check("midreset_result", observed(), 35'd0);
      check("midreset_state", 35'(dbg_state), 35'(IDLE));
      run_op(32'h4040_0000, 32'h4040_0000, 0);
      check("after_reset_op", observed(), {3'b000, 32'h4110_0000});

      // Randomized operands against the reference model
      for (int n = 0; n < 40; n++) begin
         run_op(rand_operand(), rand_operand(), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
